// File: rtl/mem_txn_sequencer_pkg.sv
// Shared encodings for the memory-port transaction sequencer: RW codes, run modes, FSM states.
package mem_txn_pkg;

  localparam logic [1:0] RW_IDLE = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;

  typedef enum logic [1:0] {
    MODE_WR    = 2'b00,
    MODE_RD    = 2'b01,
    MODE_WR_RB = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT_ACK,
    S_RELEASE,
    S_WAIT_NACK,
    S_NEXT,
    S_DONE
  } state_e;

endpackage

// File: rtl/mem_txn_sequencer_if.sv
// Memory macro A/RW/W/R port with the four-phase Ack handshake.
interface mem_txn_sequencer_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 4,
  parameter int NCH    = 2
);
  logic [ADDR_W-1:0]     A;
  logic [1:0]            RW;
  logic [NCH*DATA_W-1:0] W;
  logic [NCH-1:0]        WdataAck;
  logic [NCH*DATA_W-1:0] R;
  logic [NCH-1:0]        RDataAck;
  logic                  Ack;

  modport master (output A, RW, W, RDataAck, input WdataAck, R, Ack);
  modport slave  (input A, RW, W, RDataAck, output WdataAck, R, Ack);
endinterface

// File: rtl/mem_txn_sequencer_sync2.sv
// Two-flop synchroniser, cleared to zero on reset.
module sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mem_txn_sequencer.sv
// Programmable write/read transaction sequencer over the four-phase Ack handshake,
// with automatic read-back checking and an Ack timeout.
module mem_txn_sequencer
  import mem_txn_pkg::*;
#(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 4,
  parameter int NCH    = 2,
  parameter int CNT_W  = 8,
  parameter int TO_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  input  logic [CNT_W-1:0]  count,
  input  logic [DATA_W-1:0] seed,
  mem_txn_sequencer_if.master bus,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [TO_W-1:0]  TO_MAX  = '1;
  localparam logic [CNT_W-1:0] ERR_MAX = '1;

  state_e                        state;
  mode_e                         mode_q;
  logic                          wr_pass;
  logic [ADDR_W-1:0]             base_q, stride_q, addr_acc;
  logic [CNT_W-1:0]              count_q, idx;
  logic [DATA_W-1:0]             seed_q, dbase;
  logic [TO_W-1:0]               tcnt;
  logic                          ack_s;

  sync2 #(.W(1)) u_ack_sync (.clk(clk), .rst(rst), .d(bus.Ack), .q(ack_s));

  // Channel c pattern is dbase + c; dbase tracks seed + idx without a multiply.
  logic [NCH-1:0][DATA_W-1:0] exp_d;
  logic [NCH-1:0]             miss;
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign exp_d[c] = dbase + DATA_W'(c);
    assign miss[c]  = bus.R[c*DATA_W +: DATA_W] != exp_d[c];
  end

  logic [CNT_W:0]   n_err;
  logic [CNT_W+1:0] err_sum;
  logic [CNT_W-1:0] err_nxt;
  always_comb begin
    n_err = '0;
    if (wr_pass) n_err[0] = ~&bus.WdataAck;
    else for (int c = 0; c < NCH; c++) n_err = n_err + (CNT_W+1)'(miss[c]);
    err_sum = (CNT_W+2)'(err_cnt) + (CNT_W+2)'(n_err);
    err_nxt = (err_sum > (CNT_W+2)'(ERR_MAX)) ? ERR_MAX : err_sum[CNT_W-1:0];
  end

  wire last = (idx == count_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      mode_q       <= MODE_WR;
      wr_pass      <= 1'b0;
      base_q       <= '0;
      stride_q     <= '0;
      addr_acc     <= '0;
      count_q      <= '0;
      idx          <= '0;
      seed_q       <= '0;
      dbase        <= '0;
      tcnt         <= '0;
      bus.A        <= '0;
      bus.RW       <= RW_IDLE;
      bus.W        <= '0;
      bus.RDataAck <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      err_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mode_q   <= (mode == MODE_RSVD) ? MODE_WR : mode_e'(mode);
          wr_pass  <= (mode != MODE_RD);
          base_q   <= base;
          stride_q <= stride;
          count_q  <= count;
          seed_q   <= seed;
          addr_acc <= base;
          dbase    <= seed;
          idx      <= '0;
          busy     <= 1'b1;
          done     <= 1'b0;
          timeout  <= 1'b0;
          err_cnt  <= '0;
          state    <= (count == '0) ? S_DONE : S_SETUP;
        end
        S_SETUP: begin
          bus.A  <= addr_acc;
          bus.RW <= wr_pass ? RW_WR : RW_RD;
          bus.W  <= wr_pass ? exp_d : '0;
          tcnt   <= '0;
          state  <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          // Timeout wins over an Ack seen in the same cycle.
          if (tcnt == TO_MAX) begin
            bus.A        <= '0;
            bus.RW       <= RW_IDLE;
            bus.W        <= '0;
            bus.RDataAck <= '0;
            timeout      <= 1'b1;
            state        <= S_DONE;
          end else if (ack_s) begin
            err_cnt <= err_nxt;
            if (!wr_pass) bus.RDataAck <= '1;
            // Idle the request here so it is visible one cycle after capture.
            bus.A  <= '0;
            bus.RW <= RW_IDLE;
            bus.W  <= '0;
            state  <= S_RELEASE;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        S_RELEASE: begin
          bus.A  <= '0;
          bus.RW <= RW_IDLE;
          bus.W  <= '0;
          tcnt   <= '0;
          state  <= S_WAIT_NACK;
        end
        S_WAIT_NACK: begin
          if (tcnt == TO_MAX) begin
            bus.RDataAck <= '0;
            timeout      <= 1'b1;
            state        <= S_DONE;
          end else if (!ack_s) begin
            bus.RDataAck <= '0;
            state        <= S_NEXT;
          end else begin
            tcnt <= tcnt + TO_W'(1);
          end
        end
        S_NEXT: begin
          if (last) begin
            if (mode_q == MODE_WR_RB && wr_pass) begin
              wr_pass  <= 1'b0;
              idx      <= '0;
              addr_acc <= base_q;
              dbase    <= seed_q;
              state    <= S_SETUP;
            end else begin
              state <= S_DONE;
            end
          end else begin
            idx      <= idx + CNT_W'(1);
            addr_acc <= addr_acc + stride_q;
            dbase    <= dbase + DATA_W'(1);
            state    <= S_SETUP;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
